// File: rtl/pop_sequence_monitor.sv
// Receive-side checker for the POP pulse train (pump, MW, probe, sample).
// Measures each segment in clk_2M5 cycles and reports one set per completed cycle.
`timescale 1ns/1ps

module pop_sequence_monitor #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 20
) (
    input  logic             clk_2M5,
    input  logic             rst,
    input  logic             enable,
    input  logic             pump,
    input  logic             MW,
    input  logic             probe,
    input  logic             sample,
    output logic [CNT_W-1:0] pump_len,
    output logic [CNT_W-1:0] mw1_len,
    output logic [CNT_W-1:0] free_len,
    output logic [CNT_W-1:0] mw2_len,
    output logic [CNT_W-1:0] probe_len,
    output logic [CYC_W-1:0] cycle_len,
    output logic             meas_valid,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [15:0]      cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUMP, S_GAP1, S_MW1, S_FREE, S_MW2, S_GAP2, S_PROBE
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ORDER = 2'd1,
        ERR_SAT   = 2'd2,
        ERR_DROP  = 2'd3
    } err_t;

    localparam logic [CNT_W-1:0] SEG_MAX  = '1;
    localparam logic [CYC_W-1:0] CYC_MAX  = '1;
    localparam logic [CNT_W-1:0] SEG_ONE  = CNT_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CNT_W-1:0] SEG_ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] seg_q, seg_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             pump_prev_q;

    // Staged segment lengths of the cycle in progress
    logic [CNT_W-1:0] pump_s_q, pump_s_d;
    logic [CNT_W-1:0] mw1_s_q, mw1_s_d;
    logic [CNT_W-1:0] free_s_q, free_s_d;
    logic [CNT_W-1:0] mw2_s_q, mw2_s_d;

    logic [CNT_W-1:0] pump_len_q, mw1_len_q, free_len_q, mw2_len_q, probe_len_q;
    logic [CYC_W-1:0] cycle_len_q;
    logic             meas_valid_q, err_valid_q;
    err_t             err_code_q, err_code_d;
    logic [15:0]      cycle_count_q;

    logic pump_rise;
    logic order_err, drop_err, sat_err;
    logic err_fire, done;

    assign pump_rise = pump && !pump_prev_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        seg_d      = seg_q;
        cyc_d      = cyc_q;
        pump_s_d   = pump_s_q;
        mw1_s_d    = mw1_s_q;
        free_s_d   = free_s_q;
        mw2_s_d    = mw2_s_q;
        err_code_d = err_code_q;
        order_err  = 1'b0;
        drop_err   = 1'b0;
        err_fire   = 1'b0;
        done       = 1'b0;

        if (state_q != S_IDLE) begin
            cyc_d = cyc_q + CYC_ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pump_rise && !MW && !probe) begin
                    state_d = S_PUMP;
                    seg_d   = SEG_ONE;
                    cyc_d   = CYC_ONE;
                end
            end
            S_PUMP: begin
                if (MW || probe) begin
                    order_err = 1'b1;
                end else if (pump) begin
                    seg_d = seg_q + SEG_ONE;
                end else begin
                    pump_s_d = seg_q;
                    state_d  = S_GAP1;
                    seg_d    = SEG_ZERO;
                end
            end
            S_GAP1: begin
                if (pump || probe) begin
                    order_err = 1'b1;
                end else if (MW) begin
                    state_d = S_MW1;
                    seg_d   = SEG_ONE;
                end else begin
                    seg_d = seg_q + SEG_ONE;
                end
            end
            S_MW1: begin
                if (pump || probe) begin
                    order_err = 1'b1;
                end else if (MW) begin
                    seg_d = seg_q + SEG_ONE;
                end else begin
                    // The first MW-low sample is already one free-gap cycle
                    mw1_s_d = seg_q;
                    state_d = S_FREE;
                    seg_d   = SEG_ONE;
                end
            end
            S_FREE: begin
                if (pump || probe) begin
                    order_err = 1'b1;
                end else if (MW) begin
                    free_s_d = seg_q;
                    state_d  = S_MW2;
                    seg_d    = SEG_ONE;
                end else begin
                    seg_d = seg_q + SEG_ONE;
                end
            end
            S_MW2: begin
                if (pump || (MW && probe)) begin
                    order_err = 1'b1;
                end else if (MW) begin
                    seg_d = seg_q + SEG_ONE;
                end else begin
                    mw2_s_d = seg_q;
                    state_d = probe ? S_PROBE : S_GAP2;
                    seg_d   = probe ? SEG_ONE : SEG_ZERO;
                end
            end
            S_GAP2: begin
                if (pump || MW) begin
                    order_err = 1'b1;
                end else if (probe) begin
                    state_d = S_PROBE;
                    seg_d   = SEG_ONE;
                end else begin
                    seg_d = seg_q + SEG_ONE;
                end
            end
            S_PROBE: begin
                if (probe) begin
                    drop_err  = !sample;
                    order_err = pump || MW;
                    seg_d     = seg_q + SEG_ONE;
                end else begin
                    done = 1'b1;
                    // Back-to-back: the next pump may rise on the very edge probe falls
                    if (pump_rise && !MW) begin
                        state_d = S_PUMP;
                        seg_d   = SEG_ONE;
                        cyc_d   = CYC_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        sat_err = (state_q != S_IDLE) && ((seg_q == SEG_MAX) || (cyc_q == CYC_MAX));

        if (drop_err) begin
            err_fire   = 1'b1;
            err_code_d = ERR_DROP;
        end else if (order_err) begin
            err_fire   = 1'b1;
            err_code_d = ERR_ORDER;
        end else if (sat_err) begin
            err_fire   = 1'b1;
            err_code_d = ERR_SAT;
        end

        if (!enable) begin
            err_fire   = 1'b0;
            err_code_d = err_code_q;
        end

        // Any abort drops the partial cycle; a fresh pump rise is needed to re-arm
        if (err_fire || !enable) begin
            state_d  = S_IDLE;
            done     = 1'b0;
            pump_s_d = SEG_ZERO;
            mw1_s_d  = SEG_ZERO;
            free_s_d = SEG_ZERO;
            mw2_s_d  = SEG_ZERO;
        end
    end

    always_ff @(posedge clk_2M5 or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            seg_q         <= '0;
            cyc_q         <= '0;
            pump_prev_q   <= 1'b0;
            pump_s_q      <= '0;
            mw1_s_q       <= '0;
            free_s_q      <= '0;
            mw2_s_q       <= '0;
            pump_len_q    <= '0;
            mw1_len_q     <= '0;
            free_len_q    <= '0;
            mw2_len_q     <= '0;
            probe_len_q   <= '0;
            cycle_len_q   <= '0;
            meas_valid_q  <= 1'b0;
            err_valid_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            cycle_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            seg_q        <= seg_d;
            cyc_q        <= cyc_d;
            pump_prev_q  <= pump;
            pump_s_q     <= pump_s_d;
            mw1_s_q      <= mw1_s_d;
            free_s_q     <= free_s_d;
            mw2_s_q      <= mw2_s_d;
            meas_valid_q <= done;
            err_valid_q  <= err_fire;
            err_code_q   <= err_code_d;
            if (done) begin
                pump_len_q    <= pump_s_q;
                mw1_len_q     <= mw1_s_q;
                free_len_q    <= free_s_q;
                mw2_len_q     <= mw2_s_q;
                probe_len_q   <= seg_q;
                cycle_len_q   <= cyc_q;
                cycle_count_q <= cycle_count_q + 16'd1;
            end
        end
    end

    assign pump_len    = pump_len_q;
    assign mw1_len     = mw1_len_q;
    assign free_len    = free_len_q;
    assign mw2_len     = mw2_len_q;
    assign probe_len   = probe_len_q;
    assign cycle_len   = cycle_len_q;
    assign meas_valid  = meas_valid_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pop_sequence_monitor.sv
// Scoreboard bench for pop_sequence_monitor: stimulus queues expected reports,
// a negedge monitor pops and compares on every meas_valid / err_valid strobe.
`timescale 1ns/1ps

module tb_pop_sequence_monitor;

    logic        clk_2M5;
    logic        rst;
    logic        enable;
    logic        pump, MW, probe, sample;
    logic [15:0] pump_len, mw1_len, free_len, mw2_len, probe_len;
    logic [19:0] cycle_len;
    logic        meas_valid, err_valid;
    logic [1:0]  err_code;
    logic [15:0] cycle_count;

    pop_sequence_monitor #(.CNT_W(16), .CYC_W(20)) dut (
        .clk_2M5     (clk_2M5),
        .rst         (rst),
        .enable      (enable),
        .pump        (pump),
        .MW          (MW),
        .probe       (probe),
        .sample      (sample),
        .pump_len    (pump_len),
        .mw1_len     (mw1_len),
        .free_len    (free_len),
        .mw2_len     (mw2_len),
        .probe_len   (probe_len),
        .cycle_len   (cycle_len),
        .meas_valid  (meas_valid),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .cycle_count (cycle_count)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] code;
        logic [31:0] p, m1, f, m2, pr, cl, cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_count = 0;
    logic [31:0] last_p = 0, last_m1 = 0, last_f = 0, last_m2 = 0, last_pr = 0, last_cl = 0;

    initial clk_2M5 = 1'b0;
    always #5 clk_2M5 = ~clk_2M5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    task automatic hold(input int n, input logic p, input logic m, input logic pr, input logic s);
        for (int i = 0; i < n; i++) begin
            pump = p; MW = m; probe = pr; sample = s;
            @(posedge clk_2M5);
            #1;
        end
    endtask

    task automatic push_err(input logic [31:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code;
        e.p = last_p; e.m1 = last_m1; e.f = last_f; e.m2 = last_m2;
        e.pr = last_pr; e.cl = last_cl; e.cnt = exp_count;
        exp_q.push_back(e);
    endtask

    // Queue the expected report, then drive one clean cycle sample by sample
    task automatic good_cycle(input int p, input int g1, input int m1, input int f,
                              input int m2, input int g2, input int pr);
        exp_t e;
        exp_count = (exp_count + 1) & 32'hFFFF;
        last_p = p; last_m1 = m1; last_f = f; last_m2 = m2; last_pr = pr;
        last_cl = p + g1 + m1 + f + m2 + g2 + pr;
        e.is_err = 1'b0; e.code = 0;
        e.p = last_p; e.m1 = last_m1; e.f = last_f; e.m2 = last_m2;
        e.pr = last_pr; e.cl = last_cl; e.cnt = exp_count;
        exp_q.push_back(e);
        hold(p,  1, 0, 0, 0);
        hold(g1, 0, 0, 0, 0);
        hold(m1, 0, 1, 0, 0);
        hold(f,  0, 0, 0, 0);
        hold(m2, 0, 1, 0, 0);
        hold(g2, 0, 0, 0, 0);
        hold(pr, 0, 0, 1, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pump_len"},    32'(pump_len),    0);
        check({tag, "_mw1_len"},     32'(mw1_len),     0);
        check({tag, "_free_len"},    32'(free_len),    0);
        check({tag, "_mw2_len"},     32'(mw2_len),     0);
        check({tag, "_probe_len"},   32'(probe_len),   0);
        check({tag, "_cycle_len"},   32'(cycle_len),   0);
        check({tag, "_meas_valid"},  32'(meas_valid),  0);
        check({tag, "_err_valid"},   32'(err_valid),   0);
        check({tag, "_err_code"},    32'(err_code),    0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 0);
    endtask

    always @(negedge clk_2M5) begin
        if (meas_valid || err_valid) begin
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("meas_valid",  32'(meas_valid),  32'(!mon_e.is_err));
                check("err_valid",   32'(err_valid),   32'(mon_e.is_err));
                if (mon_e.is_err) check("err_code", 32'(err_code), mon_e.code);
                check("pump_len",    32'(pump_len),    mon_e.p);
                check("mw1_len",     32'(mw1_len),     mon_e.m1);
                check("free_len",    32'(free_len),    mon_e.f);
                check("mw2_len",     32'(mw2_len),     mon_e.m2);
                check("probe_len",   32'(probe_len),   mon_e.pr);
                check("cycle_len",   32'(cycle_len),   mon_e.cl);
                check("cycle_count", 32'(cycle_count), mon_e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d reports outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1;
        pump = 1'b0; MW = 1'b0; probe = 1'b0; sample = 1'b0;
        repeat (2) @(posedge clk_2M5);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        hold(3, 0, 0, 0, 0);

        // Nominal cycle: 250+10+5+100+5+10+50 = 430
        good_cycle(250, 10, 5, 100, 5, 10, 50);
        hold(5, 0, 0, 0, 0);

        // Back-to-back: next pump rises on the edge where probe is first low
        for (int i = 0; i < 3; i++) good_cycle(250, 10, 5, 100, 5, 10, 50);
        hold(5, 0, 0, 0, 0);

        // Minimal cycle: free gap of 1, MW2 falls straight into probe (cycle_len 12)
        good_cycle(3, 1, 2, 1, 1, 0, 4);
        hold(4, 0, 0, 0, 0);

        // Order error: MW high on the 20th pump sample
        push_err(1);
        hold(19, 1, 0, 0, 0);
        hold(1,  1, 1, 0, 0);
        hold(4,  0, 0, 0, 0);
        good_cycle(6, 2, 3, 7, 2, 3, 9);
        hold(4, 0, 0, 0, 0);

        // Sample dropout for one cycle in the middle of the probe
        push_err(3);
        hold(20, 1, 0, 0, 0);
        hold(2,  0, 0, 0, 0);
        hold(3,  0, 1, 0, 0);
        hold(8,  0, 0, 0, 0);
        hold(3,  0, 1, 0, 0);
        hold(2,  0, 0, 0, 0);
        hold(5,  0, 0, 1, 1);
        hold(1,  0, 0, 1, 0);
        hold(4,  0, 0, 1, 1);
        hold(5,  0, 0, 0, 0);

        // Saturation: pump stuck high past 65535 samples, no re-arm while still high
        push_err(2);
        hold(65545, 1, 0, 0, 0);
        hold(3, 0, 0, 0, 0);
        good_cycle(4, 1, 1, 2, 1, 1, 3);
        hold(4, 0, 0, 0, 0);

        // Async reset while in FREE: outputs clear before any clock edge
        hold(10, 1, 0, 0, 0);
        hold(2,  0, 0, 0, 0);
        hold(3,  0, 1, 0, 0);
        hold(5,  0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_count = 0;
        last_p = 0; last_m1 = 0; last_f = 0; last_m2 = 0; last_pr = 0; last_cl = 0;
        hold(2, 0, 0, 0, 0);
        rst = 1'b0;
        hold(3, 0, 0, 0, 0);

        // Enable dropped in MW2: that cycle is silently lost, the next one counts
        hold(10, 1, 0, 0, 0);
        hold(2,  0, 0, 0, 0);
        hold(3,  0, 1, 0, 0);
        hold(4,  0, 0, 0, 0);
        hold(1,  0, 1, 0, 0);
        enable = 1'b0;
        hold(2,  0, 1, 0, 0);
        hold(2,  0, 0, 0, 0);
        hold(5,  0, 0, 1, 1);
        hold(3,  0, 0, 0, 0);
        enable = 1'b1;
        hold(2, 0, 0, 0, 0);
        good_cycle(5, 3, 2, 11, 4, 1, 6);
        hold(6, 0, 0, 0, 0);

        check("reports_outstanding", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pop_sequence_monitor.md
Name: pop_sequence_monitor

Overview:
- Receive-side checker for the POP pulse train (pump, MW, probe, sample) produced by the POP timer logic.
- Measures every segment of each POP cycle in clk_2M5 cycles (400 ns resolution) and reports one measurement set per completed cycle.
- Flags out-of-order or over-long sequences.
- Sits on the 2.5 MHz domain beside the output registers and feeds debug pins and the bench scoreboard.

Parameters:
- CNT_W, 16, width of each segment counter; saturates at 2^CNT_W-1 (about 26 ms).
- CYC_W, 20, width of the whole-cycle length counter.

Ports:
- clk_2M5  in  1  2.5 MHz system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  monitor enabled; low forces IDLE with no reports.
- pump  in  1  pump gate, synchronous to clk_2M5.
- MW  in  1  microwave gate, synchronous.
- probe  in  1  probe gate, synchronous.
- sample  in  1  sample gate, synchronous.
- pump_len  out  CNT_W  pump high length.
- mw1_len  out  CNT_W  first (pi/2) MW pulse length.
- free_len  out  CNT_W  MW-low gap between the two MW pulses.
- mw2_len  out  CNT_W  second MW pulse length.
- probe_len  out  CNT_W  probe high length.
- cycle_len  out  CYC_W  cycles from first pump-high sample to last probe-high sample, inclusive.
- meas_valid  out  1  one-cycle strobe; all *_len outputs are updated together on this edge.
- err_valid  out  1  one-cycle error strobe.
- err_code  out  2  1 = unexpected signal, 2 = counter saturation, 3 = sample dropout during probe; holds until next error.
- cycle_count  out  16  completed good cycles; wraps from 65535 to 0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal pump_d register = 0.
- States: IDLE, PUMP, GAP1, MW1, FREE, MW2, GAP2, PROBE. All inputs are sampled on posedge; "rise" means the input is 1 now and was 0 on the previous sample.
- IDLE: on pump rise with MW=0 and probe=0, go to PUMP; seg_cnt=1, cyc_cnt=1. Otherwise stay.
- PUMP: while pump=1, seg_cnt++.
  - pump=0 with MW=0 and probe=0: latch pump_len=seg_cnt, go to GAP1, seg_cnt=0.
  - MW=1 or probe=1: error 1.
- GAP1: on MW=1 with pump=0 and probe=0, go to MW1, seg_cnt=1. pump=1 or probe=1: error 1.
- MW1: counts while MW=1. On MW=0, latch mw1_len and go to FREE; seg_cnt=1 if that cycle counts as a gap cycle. Precisely: free_len counts cycles with MW=0 between the pulses.
- FREE: on MW rise, latch free_len, go to MW2, seg_cnt=1. pump or probe high: error 1.
- MW2: on MW=0, latch mw2_len, go to GAP2. On probe=1 in that same cycle, go directly to PROBE.
- GAP2: on probe=1 with pump=0 and MW=0, go to PROBE, seg_cnt=1. pump or MW high: error 1.
- PROBE: counts while probe=1. sample=0 in any PROBE cycle: error 3.
  - On probe=0: latch probe_len and cycle_len, pulse meas_valid, increment cycle_count, go to IDLE.
  - If pump rises on that same edge, go straight to PUMP with counters=1 so back-to-back cycles are not lost.
- Measurement registers are staged internally and transferred to the *_len outputs only with meas_valid. Outputs hold their last good set between strobes; an aborted cycle never changes them.
- cyc_cnt increments every non-IDLE cycle.
- Saturation: if seg_cnt reaches 2^CNT_W-1 or cyc_cnt reaches 2^CYC_W-1 in any non-IDLE state, raise error 2.
- Error handling: err_valid pulses for 1 cycle, err_code is set, FSM goes to IDLE. Re-arming requires a fresh pump rise, so a stuck-high pump never re-arms.
- Error priority when several occur on the same edge: 3 > 1 > 2.
- enable=0: FSM goes to IDLE on the next edge; staged values are discarded; no strobes. Re-enabling while pump is high waits for the next pump rise.
- rst asserted mid-cycle: everything returns to reset values immediately (async); no strobe is emitted.

Test Plan:
- Nominal cycle: pump 250, gap 10, MW 5, free 100, MW 5, gap 10, probe 50 (sample high) -> meas_valid once; pump_len=250, mw1_len=5, free_len=100, mw2_len=5, probe_len=50, cycle_len=430, cycle_count=1.
- Back-to-back: pump rises on the same edge that probe falls, repeated 3 times -> 3 meas_valid strobes, cycle_count=3, identical lengths.
- Order error: MW high during PUMP at cycle 20 -> err_valid, err_code=1, outputs unchanged from prior cycle, FSM in IDLE; next clean cycle reports normally.
- Sample dropout: sample low for 1 cycle mid-probe -> err_code=3, no meas_valid, cycle_count unchanged.
- Saturation: pump held high 65535 cycles (CNT_W=16) -> err_code=2; pump held high afterwards produces no re-arm until pump goes low and rises again.
- Async reset and enable: rst pulsed in FREE -> all outputs 0 immediately, no strobes. enable dropped in MW2 -> no strobe, the following full cycle is measured correctly.
